mem_line_assembler: RTL and testbench
=====================================

MEM_LINE_ASSEMBLER -- requirements
Module: mem_line_assembler

Interface
REQ-001 SHALL have parameter EXT_MEM_DATA_WIDTH, default 40: width of one external memory beat.
REQ-002 SHALL have parameter BEATS_PER_LINE, default 2, legal range 2..16: beats per assembled line.
REQ-003 SHALL derive localparam INT_MEM_DATA_WIDTH = EXT_MEM_DATA_WIDTH*BEATS_PER_LINE; CNT_W = $clog2(BEATS_PER_LINE).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 srst  input  1  synchronous active-high reset.
REQ-007 i_mem_data  input  EXT_MEM_DATA_WIDTH  external beat.
REQ-008 i_mem_data_valid  input  1  beat present.
REQ-009 o_ready  output  1  beat accepted this cycle when high with i_mem_data_valid.
REQ-010 i_flush  input  1  discard partially assembled line.
REQ-011 o_mem_data  output  INT_MEM_DATA_WIDTH  assembled line.
REQ-012 o_mem_data_valid  output  1  line available.
REQ-013 i_ready  input  1  downstream consumes line when high with o_mem_data_valid.
REQ-014 o_beat_count  output  CNT_W  beats accepted into current partial line.

Function
REQ-015 Beat accept = i_mem_data_valid & o_ready; line consume = o_mem_data_valid & i_ready.
REQ-016 Beat ordering: first accepted beat SHALL occupy the most-significant EXT_MEM_DATA_WIDTH bits; last beat the least-significant.
REQ-017 States: FILL (beat_count < BEATS_PER_LINE-1, line completes only on a later beat) and LAST (beat_count == BEATS_PER_LINE-1); output register independently EMPTY/FULL.
REQ-018 Non-final beats SHALL be stored in an assembly register of (BEATS_PER_LINE-1) beats; beat_count increments by 1.
REQ-019 Final beat accept SHALL load o_mem_data = {assembly, i_mem_data}, set o_mem_data_valid next cycle, reset beat_count to 0 (wrap).
REQ-020 Latency: final beat accepted in cycle t -> o_mem_data_valid high in cycle t+1.
REQ-021 o_ready = ~i_flush & ~(beat_count==BEATS_PER_LINE-1 & o_mem_data_valid & ~i_ready); combinational path i_ready->o_ready permitted.
REQ-022 Non-final beats SHALL be accepted while output register FULL and stalled.
REQ-023 Simultaneous consume and final-beat accept: output register SHALL reload with new line, o_mem_data_valid stays high (back-to-back, no bubble).
REQ-024 Consume without new line: o_mem_data_valid clears next cycle; o_mem_data holds last value.
REQ-025 o_mem_data and o_mem_data_valid SHALL stay stable while valid & ~i_ready.
REQ-026 i_flush: beat_count -> 0 next cycle, assembly contents don't-care, incoming beat not accepted; output register unaffected.
REQ-027 i_flush with consume in same cycle: both take effect.
REQ-028 i_mem_data_valid low: no state change in beat path.

Reset
REQ-029 srst SHALL take priority over all inputs, including i_flush and consume.
REQ-030 After reset: beat_count 0, o_mem_data_valid 0, o_mem_data all zeros, assembly zeros, o_ready 1 (if i_flush low).
REQ-031 Reset mid-line or with line pending SHALL discard both; first beat after reset starts a new line.

Structure
REQ-032 Default widths (40, 2) and derived width function SHALL live in the shared package mem_pkg, reused by cache fill logic.
REQ-033 Beat counter with flush/wrap SHALL be sub-module mem_beat_counter; remainder inline.

Verification
REQ-034 Defaults; beats 0xAA_0000_0001 then 0xBB_0000_0002, i_ready=1 -> next cycle o_mem_data=0xAA00000001BB00000002, valid 1 cycle.
REQ-035 Output full, i_ready=0, two beats offered -> first accepted (count=1), second stalled (o_ready=0) until i_ready=1, then accepted same cycle as consume, valid stays high.
REQ-036 Continuous valid, i_ready=1, 6 beats -> 3 lines, one per 2 cycles, no dropped beats, o_ready always 1.
REQ-037 One beat, i_flush 1 cycle, two beats -> single line from post-flush beats only; count returns 0 after flush.
REQ-038 srst asserted with count=1 and line pending -> next cycle valid=0, data=0, count=0.
REQ-039 BEATS_PER_LINE=4, width 8, beats 0x11,0x22,0x33,0x44 -> 0x11223344, count sequence 1,2,3,0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-path defaults and width helpers, reused by the line assembler
// and the cache fill logic.
package mem_pkg;

    localparam int DEF_EXT_MEM_DATA_WIDTH = 40;
    localparam int DEF_BEATS_PER_LINE     = 2;

    function automatic int line_width(input int ext_width, input int beats);
        return ext_width * beats;
    endfunction

endpackage

// File: rtl/mem_beat_counter.sv
// Counts beats accepted into the partial line; clears on flush and wraps after
// the final beat of a line.
module mem_beat_counter #(
    parameter int BEATS_PER_LINE = 2,
    parameter int CNT_W          = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_flush,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(BEATS_PER_LINE - 1);

    logic [CNT_W-1:0] r_count;

    // beat counter: reset, flush and wrap all return to zero
    always_ff @(posedge clk) begin
        if (srst) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else if (i_inc) begin
            if (r_count == LAST_VAL) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST_VAL);

endmodule

// File: rtl/mem_line_assembler.sv
// Packs BEATS_PER_LINE narrow external beats into one wide line, first beat in
// the most-significant slot, with a single-entry output register.
module mem_line_assembler
    import mem_pkg::*;
#(
    parameter int EXT_MEM_DATA_WIDTH = DEF_EXT_MEM_DATA_WIDTH,
    parameter int BEATS_PER_LINE     = DEF_BEATS_PER_LINE
) (
    input  logic                                                   clk,
    input  logic                                                   srst,
    input  logic [EXT_MEM_DATA_WIDTH-1:0]                          i_mem_data,
    input  logic                                                   i_mem_data_valid,
    output logic                                                   o_ready,
    input  logic                                                   i_flush,
    output logic [line_width(EXT_MEM_DATA_WIDTH, BEATS_PER_LINE)-1:0] o_mem_data,
    output logic                                                   o_mem_data_valid,
    input  logic                                                   i_ready,
    output logic [$clog2(BEATS_PER_LINE)-1:0]                      o_beat_count
);

    localparam int INT_MEM_DATA_WIDTH = line_width(EXT_MEM_DATA_WIDTH, BEATS_PER_LINE);
    localparam int CNT_W              = $clog2(BEATS_PER_LINE);
    localparam int ASM_W              = EXT_MEM_DATA_WIDTH * (BEATS_PER_LINE - 1);

    logic [ASM_W-1:0]              r_asm;
    logic [INT_MEM_DATA_WIDTH-1:0] r_data;
    logic                          r_valid;

    logic [CNT_W-1:0] w_count;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_consume;

    // Only the final beat can be blocked, and only when the finished line
    // would have nowhere to go; this keeps i_ready -> o_ready combinational.
    assign w_ready   = ~i_flush & ~(w_last & r_valid & ~i_ready);
    assign w_accept  = i_mem_data_valid & w_ready;
    assign w_consume = r_valid & i_ready;

    mem_beat_counter #(
        .BEATS_PER_LINE (BEATS_PER_LINE),
        .CNT_W          (CNT_W)
    ) u_beat_counter (
        .clk     (clk),
        .srst    (srst),
        .i_flush (i_flush),
        .i_inc   (w_accept),
        .o_count (w_count),
        .o_last  (w_last)
    );

    // assembly register: beat k of a line lands in slot k counted from the MSB
    always_ff @(posedge clk) begin
        if (srst) begin
            r_asm <= '0;
        end else begin
            for (int i = 0; i < BEATS_PER_LINE - 1; i++) begin
                if (w_accept && !w_last && (w_count == CNT_W'(i))) begin
                    r_asm[(BEATS_PER_LINE-2-i)*EXT_MEM_DATA_WIDTH +: EXT_MEM_DATA_WIDTH] <= i_mem_data;
                end
            end
        end
    end

    // output register: a completed line overrides a same-cycle consume
    always_ff @(posedge clk) begin
        if (srst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            r_data  <= {r_asm, i_mem_data};
            r_valid <= 1'b1;
        end else if (w_consume) begin
            r_data  <= r_data;
            r_valid <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
        end
    end

    assign o_ready          = w_ready;
    assign o_mem_data       = r_data;
    assign o_mem_data_valid = r_valid;
    assign o_beat_count     = w_count;

endmodule

// File: tb/tb_mem_line_assembler.sv
// Self-checking bench: a queue-based line model checks the default-width
// instance every cycle; a second narrow 4-beat instance is checked directly.
module tb_mem_line_assembler;

    localparam int W  = 40;
    localparam int B  = 2;
    localparam int LW = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_srst, a_vin, a_flush, a_rdy;
    logic [W-1:0]  a_data;
    logic          a_ready, a_ovalid;
    logic [LW-1:0] a_odata;
    logic [0:0]    a_count;

    logic        b_srst, b_vin, b_flush, b_rdy;
    logic [7:0]  b_data;
    logic        b_ready, b_ovalid;
    logic [31:0] b_odata;
    logic [1:0]  b_count;

    mem_line_assembler u_dut_a (
        .clk              (clk),
        .srst             (a_srst),
        .i_mem_data       (a_data),
        .i_mem_data_valid (a_vin),
        .o_ready          (a_ready),
        .i_flush          (a_flush),
        .o_mem_data       (a_odata),
        .o_mem_data_valid (a_ovalid),
        .i_ready          (a_rdy),
        .o_beat_count     (a_count)
    );

    mem_line_assembler #(
        .EXT_MEM_DATA_WIDTH (8),
        .BEATS_PER_LINE     (4)
    ) u_dut_b (
        .clk              (clk),
        .srst             (b_srst),
        .i_mem_data       (b_data),
        .i_mem_data_valid (b_vin),
        .o_ready          (b_ready),
        .i_flush          (b_flush),
        .o_mem_data       (b_odata),
        .o_mem_data_valid (b_ovalid),
        .i_ready          (b_rdy),
        .o_beat_count     (b_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: beats waiting for a line, plus the line held for downstream.
    logic [W-1:0]  m_part[$];
    logic          m_valid = 1'b0;
    logic [LW-1:0] m_data  = '0;
    bit            armed   = 1'b0;
    logic          m_ready;
    logic          m_consume;
    logic          m_done;
    logic [LW-1:0] m_line;

    // Inputs are stable from posedge+1 through the next posedge, so the
    // negedge both checks the DUT and advances the model across that edge.
    always @(negedge clk) begin
        m_ready   = !a_flush && !((m_part.size() == B - 1) && m_valid && !a_rdy);
        m_consume = m_valid && a_rdy;
        if (armed) begin
            check("model_valid", 128'(a_ovalid), 128'(m_valid));
            check("model_data",  128'(a_odata),  128'(m_data));
            check("model_count", 128'(a_count),  128'(m_part.size()));
            check("model_ready", 128'(a_ready),  128'(m_ready));
        end
        if (a_srst) begin
            m_part.delete();
            m_valid = 1'b0;
            m_data  = '0;
            armed   = 1'b1;
        end else begin
            m_done = 1'b0;
            if (a_flush) begin
                m_part.delete();
            end else if (a_vin && m_ready) begin
                m_part.push_back(a_data);
                if (m_part.size() == B) begin
                    m_line = '0;
                    foreach (m_part[k]) m_line = (m_line << W) | LW'(m_part[k]);
                    m_part.delete();
                    m_done = 1'b1;
                end
            end
            if (m_done) begin
                m_data  = m_line;
                m_valid = 1'b1;
            end else if (m_consume) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic set_a(input logic s, input logic v, input logic [W-1:0] d, input logic f, input logic r);
        a_srst = s; a_vin = v; a_data = d; a_flush = f; a_rdy = r;
    endtask

    task automatic step_a(input logic s, input logic v, input logic [W-1:0] d, input logic f, input logic r);
        set_a(s, v, d, f, r);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic s, input logic v, input logic [7:0] d, input logic r);
        b_srst = s; b_vin = v; b_data = d; b_flush = 1'b0; b_rdy = r;
        @(posedge clk);
        #1;
    endtask

    int lines;
    logic [63:0] rnd;

    initial begin
        set_a(1'b1, 1'b0, '0, 1'b0, 1'b0);
        b_srst = 1'b1; b_vin = 1'b0; b_data = '0; b_flush = 1'b0; b_rdy = 1'b0;
        @(posedge clk);
        #1;
        step_a(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("rst_valid", 128'(a_ovalid), 128'(0));
        check("rst_data",  128'(a_odata),  128'(0));
        check("rst_count", 128'(a_count),  128'(0));
        check("rst_ready", 128'(a_ready),  128'(1));

        // two beats make one line, first beat on top
        step_a(1'b0, 1'b1, 40'hAA00000001, 1'b0, 1'b1);
        check("b2b_count1", 128'(a_count), 128'(1));
        check("b2b_novalid", 128'(a_ovalid), 128'(0));
        step_a(1'b0, 1'b1, 40'hBB00000002, 1'b0, 1'b1);
        check("line_valid", 128'(a_ovalid), 128'(1));
        check("line_data",  128'(a_odata),  128'(80'hAA00000001BB00000002));
        check("line_count0", 128'(a_count), 128'(0));
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("line_valid_1cyc", 128'(a_ovalid), 128'(0));
        check("line_data_hold",  128'(a_odata),  128'(80'hAA00000001BB00000002));

        // stalled output: non-final beat accepted, final beat held off
        step_a(1'b0, 1'b1, 40'hC100000001, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 40'hC200000002, 1'b0, 1'b0);
        check("stall_full", 128'(a_ovalid), 128'(1));
        step_a(1'b0, 1'b1, 40'hD100000003, 1'b0, 1'b0);
        check("stall_first_acc", 128'(a_count), 128'(1));
        for (int i = 0; i < 2; i++) begin
            set_a(1'b0, 1'b1, 40'hD200000004, 1'b0, 1'b0);
            #2;
            check("stall_ready_low", 128'(a_ready), 128'(0));
            @(posedge clk);
            #1;
            check("stall_data_stable", 128'(a_odata), 128'(80'hC100000001C200000002));
            check("stall_count", 128'(a_count), 128'(1));
        end
        set_a(1'b0, 1'b1, 40'hD200000004, 1'b0, 1'b1);
        #2;
        check("unstall_ready", 128'(a_ready), 128'(1));
        @(posedge clk);
        #1;
        check("reload_valid", 128'(a_ovalid), 128'(1));
        check("reload_data",  128'(a_odata),  128'(80'hD100000003D200000004));
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("reload_drain", 128'(a_ovalid), 128'(0));

        // continuous stream of six beats
        lines = 0;
        for (int i = 0; i < 6; i++) begin
            set_a(1'b0, 1'b1, 40'h6000000000 + 40'(i), 1'b0, 1'b1);
            #2;
            check("stream_ready", 128'(a_ready), 128'(1));
            @(posedge clk);
            #1;
            if (a_ovalid) lines++;
        end
        check("stream_lines", 128'(lines), 128'(3));
        check("stream_last",  128'(a_odata), 128'(80'h60000000046000000005));
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // flush discards the partial line and blocks the offered beat
        step_a(1'b0, 1'b1, 40'hE000000000, 1'b0, 1'b1);
        check("flush_pre", 128'(a_count), 128'(1));
        step_a(1'b0, 1'b1, 40'hE900000009, 1'b1, 1'b1);
        check("flush_count", 128'(a_count), 128'(0));
        step_a(1'b0, 1'b1, 40'hE100000001, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 40'hE200000002, 1'b0, 1'b1);
        check("flush_line", 128'(a_odata), 128'(80'hE100000001E200000002));
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // reset with partial line and pending line
        step_a(1'b0, 1'b1, 40'hF100000001, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 40'hF200000002, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 40'hF300000003, 1'b0, 1'b0);
        check("prerst_count", 128'(a_count), 128'(1));
        step_a(1'b1, 1'b1, 40'hF400000004, 1'b1, 1'b1);
        check("midrst_valid", 128'(a_ovalid), 128'(0));
        check("midrst_data",  128'(a_odata),  128'(0));
        check("midrst_count", 128'(a_count),  128'(0));

        // mixed traffic, checked by the model
        for (int i = 0; i < 300; i++) begin
            rnd = {$urandom(), $urandom()};
            step_a($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, W'(rnd),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        end
        step_a(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // four narrow beats
        step_b(1'b1, 1'b0, 8'h00, 1'b1);
        step_b(1'b0, 1'b1, 8'h11, 1'b1);
        check("n4_count1", 128'(b_count), 128'(1));
        step_b(1'b0, 1'b1, 8'h22, 1'b1);
        check("n4_count2", 128'(b_count), 128'(2));
        step_b(1'b0, 1'b1, 8'h33, 1'b1);
        check("n4_count3", 128'(b_count), 128'(3));
        check("n4_novalid", 128'(b_ovalid), 128'(0));
        step_b(1'b0, 1'b1, 8'h44, 1'b1);
        check("n4_count0", 128'(b_count), 128'(0));
        check("n4_valid",  128'(b_ovalid), 128'(1));
        check("n4_data",   128'(b_odata),  128'(32'h11223344));
        step_b(1'b0, 1'b0, 8'h00, 1'b1);
        check("n4_drain", 128'(b_ovalid), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
